// File: rtl/axi4_stream_shift_sched.sv
// rtl/axi4_stream_shift_sched.sv - per-packet shift scheduler for the byte shifter
//
// Purpose: queues byte-shift commands and admits exactly one upstream packet
// into the shifter per command. The shift value is held stable across each
// packet. The number of packets inside the shifter is bounded.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   cmd_valid_i/ready_o   shift command handshake, cmd_shift_i = byte shift
//   pkt_i_*               upstream AXI4-Stream slave side (pkt_i_tready out)
//   pkt_o_*               AXI4-Stream master side toward the shifter input
//   shift_o               shift value for the packet currently admitted
//   shf_t{valid,ready,last}_i  monitor taps on the shifter output stream
//   inflight_o            packets admitted but not yet drained by the shifter
//   pkt_cnt_o             packets released (wrapping)
//   busy_o                packet open, gap cycle, or packets in flight
//   err_o                 sticky: shifter drained a packet with none in flight
module axi4_stream_shift_sched #(
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 1,
  parameter int DEST_WIDTH     = 1,
  parameter int USER_WIDTH     = 1,
  parameter int DATA_WIDTH_B   = DATA_WIDTH / 8,
  parameter int DATA_WIDTH_B_W = $clog2(DATA_WIDTH_B),
  parameter int CMD_FIFO_DEPTH = 4,
  parameter int MAX_INFLIGHT   = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              cmd_valid_i,
  output logic                              cmd_ready_o,
  input  logic [DATA_WIDTH_B_W-1:0]         cmd_shift_i,
  input  logic [DATA_WIDTH-1:0]             pkt_i_tdata,
  input  logic [DATA_WIDTH_B-1:0]           pkt_i_tkeep,
  input  logic [DATA_WIDTH_B-1:0]           pkt_i_tstrb,
  input  logic                              pkt_i_tlast,
  input  logic [ID_WIDTH-1:0]               pkt_i_tid,
  input  logic [DEST_WIDTH-1:0]             pkt_i_tdest,
  input  logic [USER_WIDTH-1:0]             pkt_i_tuser,
  input  logic                              pkt_i_tvalid,
  output logic                              pkt_i_tready,
  output logic [DATA_WIDTH-1:0]             pkt_o_tdata,
  output logic [DATA_WIDTH_B-1:0]           pkt_o_tkeep,
  output logic [DATA_WIDTH_B-1:0]           pkt_o_tstrb,
  output logic                              pkt_o_tlast,
  output logic [ID_WIDTH-1:0]               pkt_o_tid,
  output logic [DEST_WIDTH-1:0]             pkt_o_tdest,
  output logic [USER_WIDTH-1:0]             pkt_o_tuser,
  output logic                              pkt_o_tvalid,
  input  logic                              pkt_o_tready,
  output logic [DATA_WIDTH_B_W-1:0]         shift_o,
  input  logic                              shf_tvalid_i,
  input  logic                              shf_tready_i,
  input  logic                              shf_tlast_i,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_o,
  output logic [31:0]                       pkt_cnt_o,
  output logic                              busy_o,
  output logic                              err_o
);

  localparam int PTR_W  = $clog2(CMD_FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int INFL_W = $clog2(MAX_INFLIGHT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [DATA_WIDTH_B_W-1:0] fifo_mem_q [CMD_FIFO_DEPTH];
  logic [DATA_WIDTH_B_W-1:0] fifo_mem_d [CMD_FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          fifo_cnt_q, fifo_cnt_d;
  logic [DATA_WIDTH_B_W-1:0] shift_q, shift_d;
  logic [INFL_W-1:0]         inflight_q, inflight_d;
  logic [31:0]               pkt_cnt_q, pkt_cnt_d;
  logic                      err_q, err_d;

  logic fifo_full, push, start, pass, last_hs, shf_hs;

  // Payload fields pass straight through; only valid/ready are gated.
  assign pkt_o_tdata = pkt_i_tdata;
  assign pkt_o_tkeep = pkt_i_tkeep;
  assign pkt_o_tstrb = pkt_i_tstrb;
  assign pkt_o_tlast = pkt_i_tlast;
  assign pkt_o_tid   = pkt_i_tid;
  assign pkt_o_tdest = pkt_i_tdest;
  assign pkt_o_tuser = pkt_i_tuser;

  always_comb begin
    fifo_full    = (fifo_cnt_q == CNT_W'(CMD_FIFO_DEPTH));
    push         = cmd_valid_i && !fifo_full;
    pass         = (state_q == ST_PASS);
    // A command is only poppable once registered into the queue (no bypass).
    start        = (state_q == ST_IDLE) && (fifo_cnt_q != '0) &&
                   (inflight_q < INFL_W'(MAX_INFLIGHT));
    pkt_o_tvalid = pass && pkt_i_tvalid;
    pkt_i_tready = pass && pkt_o_tready;
    last_hs      = pass && pkt_i_tvalid && pkt_o_tready && pkt_i_tlast;
    shf_hs       = shf_tvalid_i && shf_tready_i && shf_tlast_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_PASS;
      ST_PASS: if (last_hs) state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    shift_d    = shift_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = cmd_shift_i;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (start) begin
      shift_d   = fifo_mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
    if (push && !start) fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    else if (!push && start) fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
  end

  // Admission into the shifter and drain out of it cancel when simultaneous.
  always_comb begin
    inflight_d = inflight_q;
    err_d      = err_q;
    if (last_hs && !shf_hs) begin
      inflight_d = inflight_q + INFL_W'(1);
    end else if (!last_hs && shf_hs) begin
      if (inflight_q == '0) err_d = 1'b1;
      else inflight_d = inflight_q - INFL_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    fifo_mem_q <= fifo_mem_d;
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      shift_q    <= '0;
      inflight_q <= '0;
      pkt_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      shift_q    <= shift_d;
      inflight_q <= inflight_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready_o = !fifo_full;
  assign shift_o     = shift_q;
  assign inflight_o  = inflight_q;
  assign pkt_cnt_o   = pkt_cnt_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != ST_IDLE) || (inflight_q != '0);

endmodule

// File: tb/tb_axi4_stream_shift_sched.sv
// tb/tb_axi4_stream_shift_sched.sv - self-checking bench for axi4_stream_shift_sched
module tb_axi4_stream_shift_sched;
  localparam int DEPTH = 4;
  localparam int MAXI  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_shift = 2'd0;
  logic [31:0] pkt_i_tdata = '0, pkt_o_tdata;
  logic [3:0]  pkt_i_tkeep = '0, pkt_i_tstrb = '0, pkt_o_tkeep, pkt_o_tstrb;
  logic        pkt_i_tlast = 1'b0, pkt_o_tlast;
  logic [0:0]  pkt_i_tid = '0, pkt_i_tdest = '0, pkt_i_tuser = '0;
  logic [0:0]  pkt_o_tid, pkt_o_tdest, pkt_o_tuser;
  logic        pkt_i_tvalid = 1'b0, pkt_i_tready, pkt_o_tvalid, pkt_o_tready = 1'b0;
  logic [1:0]  shift_o;
  logic        shf_tvalid = 1'b0, shf_tready = 1'b0, shf_tlast = 1'b0;
  logic [1:0]  inflight;
  logic [31:0] pkt_cnt;
  logic        busy, err;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  logic [1:0] hs_shift;

  always #5 clk = ~clk;

  axi4_stream_shift_sched dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_shift_i(cmd_shift),
    .pkt_i_tdata(pkt_i_tdata), .pkt_i_tkeep(pkt_i_tkeep), .pkt_i_tstrb(pkt_i_tstrb),
    .pkt_i_tlast(pkt_i_tlast), .pkt_i_tid(pkt_i_tid), .pkt_i_tdest(pkt_i_tdest),
    .pkt_i_tuser(pkt_i_tuser), .pkt_i_tvalid(pkt_i_tvalid), .pkt_i_tready(pkt_i_tready),
    .pkt_o_tdata(pkt_o_tdata), .pkt_o_tkeep(pkt_o_tkeep), .pkt_o_tstrb(pkt_o_tstrb),
    .pkt_o_tlast(pkt_o_tlast), .pkt_o_tid(pkt_o_tid), .pkt_o_tdest(pkt_o_tdest),
    .pkt_o_tuser(pkt_o_tuser), .pkt_o_tvalid(pkt_o_tvalid), .pkt_o_tready(pkt_o_tready),
    .shift_o(shift_o),
    .shf_tvalid_i(shf_tvalid), .shf_tready_i(shf_tready), .shf_tlast_i(shf_tlast),
    .inflight_o(inflight), .pkt_cnt_o(pkt_cnt), .busy_o(busy), .err_o(err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Model: a command queue, whether a packet is currently admitted, a
  // one-cycle cooldown after each packet, and the shifter occupancy count.
  int          mq[$];
  bit          m_open = 1'b0;
  logic [1:0]  m_shift = 2'd0;
  int          m_cool = 0;
  int          m_infl = 0;
  logic [31:0] m_cnt = '0;
  bit          m_err = 1'b0;
  bit          e_st, e_ps, e_lh, e_dh;
  int          e_nxt;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_open = 1'b0; m_shift = 2'd0; m_cool = 0; m_infl = 0; m_cnt = '0; m_err = 1'b0;
    end else begin
      e_st = !m_open && m_cool == 0 && mq.size() > 0 && m_infl < MAXI;
      e_ps = cmd_valid && mq.size() < DEPTH;
      e_lh = m_open && pkt_i_tvalid && pkt_o_tready && pkt_i_tlast;
      e_dh = shf_tvalid && shf_tready && shf_tlast;
      if (m_cool > 0) m_cool--;
      if (e_st) begin
        m_shift = 2'(mq.pop_front());
        m_open  = 1'b1;
        m_cnt   = m_cnt + 32'd1;
      end
      if (e_lh) begin
        m_open = 1'b0;
        m_cool = 1;
      end
      e_nxt = m_infl + int'(e_lh) - int'(e_dh);
      if (e_nxt < 0) begin
        e_nxt = 0;
        m_err = 1'b1;
      end
      m_infl = e_nxt;
      if (e_ps) mq.push_back(int'(cmd_shift));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", cmd_ready, mq.size() < DEPTH);
      chk("pkt_i_tready", pkt_i_tready, m_open && pkt_o_tready);
      chk("pkt_o_tvalid", pkt_o_tvalid, m_open && pkt_i_tvalid);
      chk("shift_o", shift_o, m_shift);
      chk("inflight", inflight, m_infl);
      chk("pkt_cnt", pkt_cnt, m_cnt);
      chk("busy", busy, m_open || m_cool > 0 || m_infl != 0);
      chk("err", err, m_err);
      if (m_open && pkt_i_tvalid) begin
        chk("tdata", pkt_o_tdata, pkt_i_tdata);
        chk("tkeep", pkt_o_tkeep, pkt_i_tkeep);
        chk("tstrb", pkt_o_tstrb, pkt_i_tstrb);
        chk("tlast", pkt_o_tlast, pkt_i_tlast);
        chk("tid_tdest_tuser", {pkt_o_tid, pkt_o_tdest, pkt_o_tuser},
            {pkt_i_tid, pkt_i_tdest, pkt_i_tuser});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; cmd_valid = 1'b0; pkt_i_tvalid = 1'b0; pkt_i_tlast = 1'b0;
    pkt_o_tready = 1'b0; shf_tvalid = 1'b0; shf_tready = 1'b0; shf_tlast = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic push_cmd(input logic [1:0] s);
    int n = 0;
    cmd_valid = 1'b1; cmd_shift = s;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin n++; @(negedge clk); end
    if (!cmd_ready) chk("push_timeout", 1, 0);
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input bit last);
    int n = 0;
    pkt_i_tdata = d; pkt_i_tkeep = d[3:0]; pkt_i_tstrb = d[7:4];
    pkt_i_tid = d[8]; pkt_i_tdest = d[9]; pkt_i_tuser = d[10];
    pkt_i_tlast = last; pkt_i_tvalid = 1'b1;
    @(negedge clk);
    while (!pkt_i_tready && n < 50) begin n++; @(negedge clk); end
    if (!pkt_i_tready) chk("beat_timeout", 1, 0);
    hs_shift = shift_o;
    tick;
    pkt_i_tvalid = 1'b0; pkt_i_tlast = 1'b0;
  endtask

  task automatic shf_drain;
    shf_tvalid = 1'b1; shf_tready = 1'b1; shf_tlast = 1'b1;
    tick;
    shf_tvalid = 1'b0; shf_tready = 1'b0; shf_tlast = 1'b0;
  endtask

  initial begin
    do_reset;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tready", pkt_i_tready, 0);
    tick;

    // One command, shift=1, three-beat packet.
    push_cmd(2'd1);
    pkt_o_tready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      send_beat(32'hA5A5_0100 + b * 32'h0111_0357, b == 2);
      chk("t1_beat_shift", hs_shift, 1);
    end
    @(negedge clk);
    chk("t1_gap_tready", pkt_i_tready, 0);
    chk("t1_gap_busy", busy, 1);
    chk("t1_inflight", inflight, 1);
    chk("t1_pkt_cnt", pkt_cnt, 1);
    tick;
    @(negedge clk);
    chk("t1_idle_tvalid", pkt_o_tvalid, 0);
    tick;

    // Upstream waits for a command; shift=3 releases it two cycles later.
    do_reset;
    pkt_o_tready = 1'b1; pkt_i_tvalid = 1'b1; pkt_i_tdata = 32'h1234_5678; pkt_i_tlast = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_hold", pkt_i_tready, 0);
      tick;
    end
    cmd_valid = 1'b1; cmd_shift = 2'd3;
    tick;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("t2_wait", pkt_i_tready, 0);
    tick;
    @(negedge clk);
    chk("t2_release", pkt_i_tready, 1);
    chk("t2_shift", shift_o, 3);
    tick;
    send_beat(32'h8765_4321, 1'b1);
    chk("t2_last_shift", hs_shift, 3);

    // In-flight limit: third packet held until the shifter drains one.
    do_reset;
    push_cmd(2'd0); push_cmd(2'd1); push_cmd(2'd2);
    pkt_o_tready = 1'b1;
    send_beat(32'h0000_0AAA, 1'b1);
    send_beat(32'h0000_0BBB, 1'b1);
    pkt_i_tvalid = 1'b1; pkt_i_tlast = 1'b1; pkt_i_tdata = 32'h0000_0CCC;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_held", pkt_i_tready, 0);
      tick;
    end
    @(negedge clk);
    chk("t3_infl_full", inflight, 2);
    tick;
    shf_drain;
    send_beat(32'h0000_0CCC, 1'b1);
    chk("t3_third_shift", hs_shift, 2);
    @(negedge clk);
    chk("t3_infl_after", inflight, 2);
    chk("t3_pkt_cnt", pkt_cnt, 3);
    tick;

    // Queue fills while a packet is stalled; fifth command waits for a pop.
    do_reset;
    push_cmd(2'd1);
    pkt_i_tvalid = 1'b1; pkt_i_tlast = 1'b1; pkt_i_tdata = 32'h0000_0DDD;
    tick; tick;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_shift = 2'(i);
      @(negedge clk);
      chk("t4_ready", cmd_ready, 1);
      tick;
    end
    cmd_shift = 2'd2;
    @(negedge clk);
    chk("t4_full", cmd_ready, 0);
    tick;
    pkt_o_tready = 1'b1;
    @(negedge clk);
    chk("t4_full_hs", cmd_ready, 0);
    tick;
    pkt_i_tvalid = 1'b0;
    @(negedge clk);
    chk("t4_full_gap", cmd_ready, 0);
    tick;
    @(negedge clk);
    chk("t4_full_idle", cmd_ready, 0);
    tick;
    @(negedge clk);
    chk("t4_accept", cmd_ready, 1);
    tick;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("t4_pkt_cnt", pkt_cnt, 2);
    tick;

    // Single-beat packet with toggling downstream ready; shift held through gap.
    do_reset;
    push_cmd(2'd2); push_cmd(2'd0);
    pkt_i_tvalid = 1'b1; pkt_i_tlast = 1'b1; pkt_i_tdata = 32'h0000_0EEE;
    begin
      int c = 0;
      bit got = 1'b0;
      while (!got && c < 20) begin
        pkt_o_tready = c[0];
        @(negedge clk);
        if (pkt_i_tready) got = 1'b1;
        else begin tick; c++; end
      end
      if (!got) chk("t5_timeout", 1, 0);
    end
    chk("t5_hs_shift", shift_o, 2);
    tick;
    pkt_o_tready = 1'b0;
    @(negedge clk);
    chk("t5_gap_shift", shift_o, 2);
    chk("t5_gap_tvalid", pkt_o_tvalid, 0);
    tick;
    @(negedge clk);
    chk("t5_idle_shift", shift_o, 2);
    tick;
    @(negedge clk);
    chk("t5_next_shift", shift_o, 0);
    chk("t5_next_tvalid", pkt_o_tvalid, 1);
    tick;
    pkt_i_tvalid = 1'b0;

    // Drain with nothing in flight raises sticky error; reset clears it.
    do_reset;
    shf_drain;
    @(negedge clk);
    chk("t6_err", err, 1);
    chk("t6_infl", inflight, 0);
    tick; tick;
    @(negedge clk);
    chk("t6_err_sticky", err, 1);
    tick;
    push_cmd(2'd1);
    pkt_o_tready = 1'b1;
    send_beat(32'h0000_0FFF, 1'b1);
    @(negedge clk);
    chk("t6_pkt_cnt", pkt_cnt, 1);
    tick;
    do_reset;
    @(negedge clk);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_cnt", pkt_cnt, 0);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
